// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU load/store path and the VGA texture fetcher.
// The CPU has priority, and a saturating starvation counter bounds how long the VGA waits.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;
  logic       rd_v_q, rd_v_d;
  logic       rd_owner_q, rd_owner_d;
  logic       force_vga;

  // Grants are gated by reset so that nothing reaches memory while reset is held.
  always_comb begin
    force_vga = vga_req && (starve_q == STARVE_LIM);
    vga_gnt   = reset && vga_req && (!cpu_req || force_vga);
    cpu_gnt   = reset && cpu_req && !vga_gnt;
    mem_en    = cpu_gnt | vga_gnt;
    mem_we    = cpu_gnt & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_addr  = vga_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!vga_req || vga_gnt) begin
      starve_d = 8'd0;
    end else if (cpu_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 8'd1;
    end
    rd_v_d     = mem_en & ~mem_we;
    rd_owner_d = vga_gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q   <= 8'd0;
      rd_v_q     <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_v_q     <= rd_v_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Return data is steered by the owner tag captured on the grant edge.
  always_comb begin
    cpu_rvalid = rd_v_q & ~rd_owner_q;
    vga_rvalid = rd_v_q &  rd_owner_q;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    vga_rdata  = vga_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, starvation and reset sequences,
// then randomized traffic checked against a cycle-level reference model.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, vga_req;
  logic [AW-1:0] cpu_addr, vga_addr;
  logic [DW-1:0] cpu_wdata, mem_rdata;
  logic          cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid;
  logic          mem_en, mem_we;
  logic [DW-1:0] cpu_rdata, vga_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwdata;
    logic        vreq;
    logic [31:0] vaddr, mrdata;
    logic        e_cg, e_vg, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_crv, e_vrv;
    logic [31:0] e_crd, e_vrd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] act_gnt();
    return {60'd0, cpu_gnt, vga_gnt, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [127:0] act_rsp();
    return {62'd0, cpu_rvalid, vga_rvalid, cpu_rdata, vga_rdata};
  endfunction

  function automatic logic [127:0] pk_gnt(input logic cg, vg, en, we, input logic [31:0] a, w);
    return {60'd0, cg, vg, en, we, a, w};
  endfunction

  function automatic logic [127:0] pk_rsp(input logic crv, vrv, input logic [31:0] crd, vrd);
    return {62'd0, crv, vrv, crd, vrd};
  endfunction

  task automatic set_in(input logic creq, cwe, input logic [31:0] caddr, cwdata,
                        input logic vreq, input logic [31:0] vaddr, mrd);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata;
    vga_req = vreq; vga_addr = vaddr; mem_rdata = mrd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // --- reset held low with both requesters asking ---
    reset = 1'b0;
    set_in(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h800, 32'h0);
    #13;
    check("reset_outputs", {124'd0, cpu_gnt, vga_gnt, mem_en, cpu_rvalid | vga_rvalid}, 128'd0);
    check("reset_mem_we", {127'd0, mem_we}, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_first_grant", {126'd0, cpu_gnt, vga_gnt}, {126'd0, 2'b10});
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h5A5A_0001);
    @(negedge clk);
    check("release_first_read_return", act_rsp(), pk_rsp(1'b1, 1'b0, 32'h5A5A_0001, 32'h0));
    @(posedge clk); #1;

    // --- directed vector table ---
    vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hAAAA5555,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h800, 32'h11111111,
                1'b0, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1, 1'b0, 32'h11111111, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h22222222,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h22222222};
    vecs[7] = '{1'b1, 1'b0, 32'h20, 32'hFFFF0000, 1'b1, 32'h804, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'hFFFF0000, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h804, 32'h33333333,
                1'b0, 1'b1, 1'b1, 1'b0, 32'h804, 32'h0, 1'b1, 1'b0, 32'h33333333, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h44444444,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h44444444};

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwdata,
             vecs[i].vreq, vecs[i].vaddr, vecs[i].mrdata);
      @(negedge clk);
      $display("[TB] vec %0d cg=%b vg=%b en=%b we=%b addr=%h crv=%b vrv=%b",
               i, cpu_gnt, vga_gnt, mem_en, mem_we, mem_addr, cpu_rvalid, vga_rvalid);
      check($sformatf("vec%0d_grant", i), act_gnt(),
            pk_gnt(vecs[i].e_cg, vecs[i].e_vg, vecs[i].e_en, vecs[i].e_we,
                   vecs[i].e_addr, vecs[i].e_wdata));
      check($sformatf("vec%0d_return", i), act_rsp(),
            pk_rsp(vecs[i].e_crv, vecs[i].e_vrv, vecs[i].e_crd, vecs[i].e_vrd));
      @(posedge clk); #1;
    end

    // --- starvation: both held high, VGA every 9th cycle ---
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 27; k++) begin
      set_in(1'b1, 1'b0, 32'(k * 4), 32'h0, 1'b1, 32'h900, 32'(k));
      @(negedge clk);
      $display("[TB] starve cycle %0d cg=%b vg=%b", k, cpu_gnt, vga_gnt);
      check($sformatf("starve%0d_grant", k), {126'd0, cpu_gnt, vga_gnt},
            {126'd0, (k % 9) != 8, (k % 9) == 8});
      if (k > 0)
        check($sformatf("starve%0d_owner", k), {126'd0, cpu_rvalid, vga_rvalid},
              {126'd0, ((k - 1) % 9) != 8, ((k - 1) % 9) == 8});
      @(posedge clk); #1;
    end

    // --- VGA read in flight when reset drops ---
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA00, 32'h0);
    @(negedge clk);
    check("inflight_vga_grant", {126'd0, cpu_gnt, vga_gnt}, {126'd0, 2'b01});
    @(posedge clk); #2;
    reset = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hBADBAD00);
    #1;
    check("inflight_dropped", act_rsp(), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("[TB] post-reset cycle %0d crv=%b vrv=%b", k, cpu_rvalid, vga_rvalid);
      check($sformatf("post_reset_quiet%0d", k), act_rsp(), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // --- randomized traffic against a reference model ---
    begin
      int   waited;
      bit   pend_v, pend_vga;
      logic creq, cwe, vreq, ec, ev;
      logic [31:0] caddr, cwdata, vaddr, mrd;
      logic crv, vrv;
      waited = 0; pend_v = 0; pend_vga = 0;
      creq = 0; cwe = 0; vreq = 0; ec = 0; ev = 0;
      caddr = 0; cwdata = 0; vaddr = 0;
      for (int c = 0; c < 1500; c++) begin
        // Requests not granted stay put; otherwise draw fresh ones.
        if (!(creq && !ec)) begin
          creq   = ($urandom_range(0, 99) < 60);
          cwe    = $urandom_range(0, 1) == 1;
          caddr  = $urandom & 32'hFFFF_FFFC;
          cwdata = $urandom;
        end
        if (!(vreq && !ev)) begin
          vreq  = ($urandom_range(0, 99) < 50);
          vaddr = 32'h0001_0000 + 32'($urandom_range(0, 2239) * 4);
        end
        mrd = $urandom;
        set_in(creq, cwe, caddr, cwdata, vreq, vaddr, mrd);

        ev  = vreq && (!creq || waited == SMAX);
        ec  = creq && !ev;
        crv = pend_v && !pend_vga;
        vrv = pend_v && pend_vga;

        @(negedge clk);
        check($sformatf("rand%0d_grant", c), act_gnt(),
              pk_gnt(ec, ev, ec || ev, ec && cwe,
                     ec ? caddr : (ev ? vaddr : 32'h0), ec ? cwdata : 32'h0));
        check($sformatf("rand%0d_return", c), act_rsp(),
              pk_rsp(crv, vrv, crv ? mrd : 32'h0, vrv ? mrd : 32'h0));

        if (vreq && !ev) waited = (waited < SMAX) ? waited + 1 : SMAX;
        else             waited = 0;
        pend_v   = (ec && !cwe) || ev;
        pend_vga = ev;
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
